seq_divider: RTL and testbench
==============================

# seq_divider

Sequential restoring unsigned divider, the inverse of the 4x4 array multiplier: it takes a 2W-bit dividend and a W-bit divisor and produces a 2W-bit quotient and a W-bit remainder, one quotient bit per clock. It sits beside the multiplier in the Tiny Tapeout user design, so a multiplier product can be divided back by either operand to self-check it.

## Interface
- W, default 4: divisor/remainder width; dividend and quotient are 2W bits.
- clk  input  1  single clock, all state on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  request; sampled only in IDLE.
- dividend  input  2W  numerator, captured on accepted start.
- divisor  input  W  denominator, captured on accepted start.
- busy  output  1  high whenever state is not IDLE.
- done  output  1  one-cycle pulse, results valid.
- quotient  output  2W  result, held until the next accepted start.
- remainder  output  W  result, held until the next accepted start.
- dbz  output  1  divide-by-zero flag, held with results.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: start=1 captures the operands, clears the partial remainder R (W+1 bits), loads the iteration counter with 2W, clears dbz, and moves to RUN.
- RUN, each cycle:
  - R = {R[W-1:0], next dividend bit (MSB first)}.
  - If R >= {1'b0, divisor}, then R -= divisor and the quotient bit is 1; otherwise the quotient bit is 0.
  - Quotient bits shift in at the LSB.
  - The counter decrements; at count 1 the state moves to DONE.
- DONE: quotient and remainder (R[W-1:0]) registers are updated, done=1, then the state returns to IDLE. A start in DONE is ignored.
- Start while busy is ignored. Operand inputs may change freely after capture.
- Invariant for divisor != 0: dividend == quotient*divisor + remainder, with remainder < divisor.
- Divisor == 0 without the feature below: the algorithm naturally gives quotient = all ones and remainder = dividend[W-1:0].
- All arithmetic is unsigned. There is no overflow case because the quotient is 2W wide.

## Timing
- Reset values: state IDLE; busy 0, done 0, quotient 0, remainder 0, dbz 0; internal registers 0.
- Reset asserted mid-RUN or in DONE aborts immediately: no done pulse, outputs cleared.
- Start accepted on edge 0. busy rises after edge 0. The RUN edges are 1..2W. DONE occupies the cycle after edge 2W, with done=1 and results valid in that cycle. busy falls after edge 2W+1.
- Latency from start to done is 2W+1 cycles (9 for W=4). Minimum start-to-start interval is 2W+2.
- The result outputs are registered and change only on the DONE transition.

## Configuration
- SEQ_DIVIDER_DBZ_EN defined:
  - A divisor of 0 at start goes IDLE to DONE directly; done is asserted 1 cycle after start.
  - Outputs: quotient = all ones, remainder = dividend[W-1:0], dbz = 1.
- SEQ_DIVIDER_DBZ_EN undefined:
  - No special case; latency is always 2W+1.
  - dbz is tied 0.
  - Results for divisor 0 are the same natural values as above.

## Structure
- Package seq_divider_pkg holds:
  - the state enum (IDLE/RUN/DONE);
  - the default width constant DIV_W = 4;
  - the reset-value constants.
- Sub-module div_step (combinational): inputs are R, the next dividend bit and the divisor; outputs are the next R and the quotient bit. It is instanced once inside the RUN datapath.
- The top level holds the FSM, the counter, and the operand/result registers.

## Test plan
- 143 / 11 -> done at cycle 9; quotient 13, remainder 0, dbz 0.
- 200 / 15 -> quotient 13, remainder 5; 255 / 1 -> quotient 255, remainder 0; 0 / 7 -> quotient 0, remainder 0.
- 100 / 0 -> quotient 255, remainder 4, with:
  - dbz=1 and done at cycle 1 when SEQ_DIVIDER_DBZ_EN is defined;
  - dbz=0 and done at cycle 9 when it is undefined.
- Start 50/5, then start 99/9 at cycle 3 -> the second start is ignored; result is quotient 10, remainder 0 with a single done pulse.
- Start 143/11, then assert rst at cycle 4 -> all outputs are 0 and there is no done pulse. A fresh start 12/5 afterwards -> quotient 2, remainder 2.
- Exhaustive sweep of all 256 dividends x 15 nonzero divisors against the quotient*divisor + remainder invariant. Check that quotient and remainder hold unchanged between done pulses.

Source files
------------

// File: rtl/seq_divider_pkg.sv
// Shared state encoding, default width and reset values for seq_divider.
package seq_divider_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } div_state_t;

  localparam int         DIV_W     = 4;
  localparam div_state_t RST_STATE = S_IDLE;
  localparam logic       RST_FLAG  = 1'b0;

  // Counter must hold the value 2W.
  function automatic int cnt_bits(input int w);
    return $clog2(2 * w + 1);
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in a dividend bit, subtract divisor if it fits.
module div_step #(
  parameter int W = 4
) (
  input  logic [W:0]   i_rem,
  input  logic         i_bit,
  input  logic [W-1:0] i_divisor,
  output logic [W:0]   o_rem,
  output logic         o_qbit
);

  logic [W:0] w_trial;
  logic [W:0] w_dvs;
  logic       w_unused;

  // R stays below the divisor, so its top bit never reaches the trial value.
  assign w_unused = i_rem[W];
  assign w_trial  = {i_rem[W-1:0], i_bit};
  assign w_dvs    = {1'b0, i_divisor};
  assign o_qbit   = (w_trial >= w_dvs);
  assign o_rem    = o_qbit ? (w_trial - w_dvs) : w_trial;

endmodule

// File: rtl/seq_divider.sv
// Restoring unsigned divider, one quotient bit per clock, done 2W+1 cycles after start; start ignored while busy.
// SEQ_DIVIDER_DBZ_EN: a zero divisor finishes one cycle after start and raises dbz.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int W = DIV_W
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_start,
  input  logic [2*W-1:0] i_dividend,
  input  logic [W-1:0]   i_divisor,
  output logic           o_busy,
  output logic           o_done,
  output logic [2*W-1:0] o_quotient,
  output logic [W-1:0]   o_remainder,
  output logic           o_dbz
);

  localparam int          CW       = cnt_bits(W);
  localparam logic [CW-1:0] CNT_LOAD = CW'(2 * W);

  div_state_t     r_state;
  div_state_t     w_state_nxt;
  logic [2*W-1:0] r_dvd;
  logic [2*W-1:0] r_quo_sh;
  logic [2*W-1:0] r_quotient;
  logic [W-1:0]   r_dvs;
  logic [W-1:0]   r_remainder;
  logic [W:0]     r_rem;
  logic [W:0]     w_rem_nxt;
  logic [CW-1:0]  r_cnt;
  logic           w_qbit;
  logic           w_accept;
  logic           w_last;
  logic           w_zero_dvs;

  assign w_accept = (r_state == S_IDLE) && i_start;
  assign w_last   = (r_state == S_RUN) && (r_cnt == CW'(1));

`ifdef SEQ_DIVIDER_DBZ_EN
  assign w_zero_dvs = (i_divisor == '0);
`else
  assign w_zero_dvs = 1'b0;
`endif

  div_step #(.W(W)) u_step (
    .i_rem     (r_rem),
    .i_bit     (r_dvd[2*W-1]),
    .i_divisor (r_dvs),
    .o_rem     (w_rem_nxt),
    .o_qbit    (w_qbit)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= RST_STATE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_state_nxt = w_zero_dvs ? S_DONE : S_RUN;
      S_RUN:   if (r_cnt == CW'(1)) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_dvd       <= '0;
      r_dvs       <= '0;
      r_rem       <= '0;
      r_quo_sh    <= '0;
      r_cnt       <= '0;
      r_quotient  <= '0;
      r_remainder <= '0;
    end else if (w_accept) begin
      r_dvd    <= i_dividend;
      r_dvs    <= i_divisor;
      r_rem    <= '0;
      r_quo_sh <= '0;
      r_cnt    <= CNT_LOAD;
      if (w_zero_dvs) begin
        r_quotient  <= '1;
        r_remainder <= i_dividend[W-1:0];
      end
    end else if (r_state == S_RUN) begin
      r_dvd    <= r_dvd << 1;
      r_rem    <= w_rem_nxt;
      r_quo_sh <= {r_quo_sh[2*W-2:0], w_qbit};
      r_cnt    <= r_cnt - CW'(1);
      // Results land on the edge entering DONE so they are valid with done.
      if (w_last) begin
        r_quotient  <= {r_quo_sh[2*W-2:0], w_qbit};
        r_remainder <= w_rem_nxt[W-1:0];
      end
    end
  end

`ifdef SEQ_DIVIDER_DBZ_EN
  logic r_dbz;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)         r_dbz <= RST_FLAG;
    else if (w_accept) r_dbz <= w_zero_dvs;
  end

  assign o_dbz = r_dbz;
`else
  assign o_dbz = 1'b0;
`endif

  assign o_busy      = (r_state != S_IDLE);
  assign o_done      = (r_state == S_DONE);
  assign o_quotient  = r_quotient;
  assign o_remainder = r_remainder;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed cases, randomized vectors and an exhaustive sweep.
`timescale 1ns/1ps
module tb_seq_divider;

  localparam int W = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       dbz;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] last_q;
  logic [3:0] last_r;

  always #5 clk = ~clk;

  seq_divider #(.W(W)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_start     (start),
    .i_dividend  (dividend),
    .i_divisor   (divisor),
    .o_busy      (busy),
    .o_done      (done),
    .o_quotient  (quotient),
    .o_remainder (remainder),
    .o_dbz       (dbz)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_vec++;
    if (obs !== want) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, want, $time);
    end
  endtask

  // Issue one division and check result, latency, hold behaviour and single done pulse.
  // poke_at > 0 raises a competing start (99/9) that many cycles after the accepted start.
  task automatic run_div(input logic [7:0] dvd, input logic [3:0] dvs, input int poke_at);
    int         lat;
    int         n_done;
    int         want_lat;
    bit         got;
    bit         hold_ok;
    logic [7:0] want_q;
    logic [3:0] want_r;
    logic       want_dbz;

    if (dvs == 4'd0) begin
      want_q = 8'hFF;
      want_r = dvd[3:0];
    end else begin
      want_q = dvd / {4'd0, dvs};
      want_r = 4'(dvd % {4'd0, dvs});
    end
`ifdef SEQ_DIVIDER_DBZ_EN
    want_lat = (dvs == 4'd0) ? 1 : 2 * W + 1;
    want_dbz = (dvs == 4'd0);
`else
    want_lat = 2 * W + 1;
    want_dbz = 1'b0;
`endif

    @(negedge clk);
    start    = 1'b1;
    dividend = dvd;
    divisor  = dvs;
    lat      = 0;
    got      = 1'b0;
    hold_ok  = 1'b1;
    while (!got && lat < 30) begin
      @(posedge clk);
      #1;
      lat++;
      if (lat == poke_at) begin
        start    = 1'b1;
        dividend = 8'd99;
        divisor  = 4'd9;
      end else begin
        start    = 1'b0;
        dividend = 8'($urandom);
        divisor  = 4'($urandom);
      end
      if (done) got = 1'b1;
      else if (quotient !== last_q || remainder !== last_r) hold_ok = 1'b0;
    end
    start = 1'b0;

    chk("done_seen", 32'(got), 32'd1);
    chk("latency", lat, want_lat);
    chk("quotient", 32'(quotient), 32'(want_q));
    chk("remainder", 32'(remainder), 32'(want_r));
    chk("dbz", 32'(dbz), 32'(want_dbz));
    chk("busy_at_done", 32'(busy), 32'd1);
    chk("hold_during_run", 32'(hold_ok), 32'd1);
    last_q = want_q;
    last_r = want_r;

    n_done = 0;
    repeat (2) begin
      @(posedge clk);
      #1;
      if (done) n_done++;
    end
    chk("single_done", n_done, 0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("q_held", 32'(quotient), 32'(want_q));
    chk("r_held", 32'(remainder), 32'(want_r));
  endtask

  initial begin
    int n_done;

    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    last_q   = '0;
    last_r   = '0;
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_quotient", 32'(quotient), 32'd0);
    chk("rst_remainder", 32'(remainder), 32'd0);
    chk("rst_dbz", 32'(dbz), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_div(8'd143, 4'd11, 0);
    run_div(8'd200, 4'd15, 0);
    run_div(8'd255, 4'd1, 0);
    run_div(8'd0, 4'd7, 0);
    run_div(8'd100, 4'd0, 0);
    run_div(8'd50, 4'd5, 3);

    // Reset in the middle of a run aborts it and clears the outputs.
    @(negedge clk);
    start    = 1'b1;
    dividend = 8'd143;
    divisor  = 4'd11;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_quotient", 32'(quotient), 32'd0);
    chk("abort_remainder", 32'(remainder), 32'd0);
    chk("abort_dbz", 32'(dbz), 32'd0);
    @(negedge clk);
    rst    = 1'b0;
    last_q = '0;
    last_r = '0;
    n_done = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (done) n_done++;
    end
    chk("abort_no_done", n_done, 0);
    run_div(8'd12, 4'd5, 0);

    for (int k = 0; k < 60; k++) begin
      run_div(8'($urandom), 4'($urandom), int'($urandom_range(0, 8)));
    end

    for (int d = 0; d < 256; d++) begin
      for (int s = 1; s < 16; s++) begin
        run_div(8'(d), 4'(s), 0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
